// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point alignment pipeline: default
// field widths, significand/exponent typedefs and the guard/round/sticky
// triple.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef logic [FP_MAN_W:0]   fp_sig_t;
  typedef logic [FP_EXP_W-1:0] fp_exp_t;

  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } fp_grs_t;

  localparam fp_grs_t GRS_ZERO = '{g: 1'b0, r: 1'b0, s: 1'b0};

  // Pack guard, round and sticky into the shared struct.
  function automatic fp_grs_t make_grs(input logic g, input logic r, input logic s);
    fp_grs_t res;
    res.g = g;
    res.r = r;
    res.s = s;
    return res;
  endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Right-shifts a significand by an exponent difference and, when
// FP_ALIGN_STICKY_EN is defined, extracts guard/round/sticky from the
// bits that fall off. Without the macro the shifted-out bits are simply
// truncated and grs is zero.
module fp_shift_sticky
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [MAN_W:0]   sig_i,
  input  logic [EXP_W-1:0] diff_i,
  output logic [MAN_W:0]   sig_o,
  output fp_grs_t          grs_o
);

`ifdef FP_ALIGN_STICKY_EN
  // Shifts beyond MAN_W+3 give the same result as MAN_W+3 (value gone,
  // everything folded into sticky), so the amount is clamped there. The
  // MAN_W+4 low bits of the extended vector keep every shifted-out bit.
  localparam int EXT_W = 2 * MAN_W + 5;
  localparam int SAT   = MAN_W + 3;

  logic [31:0]      shamt_s;
  logic [EXT_W-1:0] ext_s;

  // Clamp the shift, shift the extended significand, split value and G/R/S.
  always_comb begin
    shamt_s = (32'(diff_i) > 32'(SAT)) ? 32'(SAT) : 32'(diff_i);
    ext_s   = {sig_i, {(MAN_W + 4){1'b0}}} >> shamt_s;
    sig_o   = ext_s[EXT_W-1:MAN_W+4];
    grs_o   = make_grs(ext_s[MAN_W+3], ext_s[MAN_W+2], |ext_s[MAN_W+1:0]);
  end
`else
  // Plain truncating shift; large differences naturally shift to zero.
  always_comb begin
    sig_o = sig_i >> diff_i;
    grs_o = GRS_ZERO;
  end
`endif

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment for FP add/sub. Stage 1 decodes both
// operands, picks the larger magnitude and registers the exponent
// difference; stage 2 shifts the smaller significand and registers all
// outputs. Optional sticky collection is enabled by FP_ALIGN_STICKY_EN.
module fp_align_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] a_frac,
  input  logic [MAN_W-1:0] b_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W:0]   big_sig,
  output logic [MAN_W:0]   small_sig,
  output logic [2:0]       grs,
  output logic [EXP_W-1:0] exp_out,
  output logic             swapped
);

  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W - 1){1'b0}}, 1'b1};

  logic             a_hid_s, b_hid_s, b_big_s;
  logic [EXP_W-1:0] a_eff_s, b_eff_s;
  logic [MAN_W:0]   a_sig_s, b_sig_s;
  logic [MAN_W:0]   big_d, small_d;
  logic [EXP_W-1:0] exp_d, diff_d;
  logic             swap_d;

  logic             s1_valid_q, s1_swap_q;
  logic [MAN_W:0]   s1_big_q, s1_small_q;
  logic [EXP_W-1:0] s1_exp_q, s1_diff_q;

  logic             out_valid_q, swap_q;
  logic [MAN_W:0]   big_q, small_q;
  logic [EXP_W-1:0] exp_q;
  fp_grs_t          grs_q;

  logic             s2_en_s;
  logic [MAN_W:0]   shift_sig_s;
  fp_grs_t          shift_grs_s;

  // Stage 2 loads when empty or when its result is being taken; stage 1
  // loads when empty or when stage 2 loads.
  assign s2_en_s  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;

  // Decode operands (subnormals use exponent 1, hidden 0) and select the larger.
  always_comb begin
    a_hid_s = (a_exp != EXP_ZERO);
    b_hid_s = (b_exp != EXP_ZERO);
    a_eff_s = a_hid_s ? a_exp : EXP_ONE;
    b_eff_s = b_hid_s ? b_exp : EXP_ONE;
    a_sig_s = {a_hid_s, a_frac};
    b_sig_s = {b_hid_s, b_frac};
    b_big_s = (b_eff_s > a_eff_s) || ((b_eff_s == a_eff_s) && (b_frac > a_frac));
    if (b_big_s) begin
      big_d   = b_sig_s;
      small_d = a_sig_s;
      exp_d   = b_eff_s;
      diff_d  = b_eff_s - a_eff_s;
      swap_d  = 1'b1;
    end else begin
      big_d   = a_sig_s;
      small_d = b_sig_s;
      exp_d   = a_eff_s;
      diff_d  = a_eff_s - b_eff_s;
      swap_d  = 1'b0;
    end
  end

  // Stage 1 register: capture the selected pair and exponent difference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_exp_q   <= '0;
      s1_diff_q  <= '0;
      s1_swap_q  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_big_q   <= big_d;
        s1_small_q <= small_d;
        s1_exp_q   <= exp_d;
        s1_diff_q  <= diff_d;
        s1_swap_q  <= swap_d;
      end
    end
  end

  fp_shift_sticky #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_shift (
    .sig_i (s1_small_q),
    .diff_i(s1_diff_q),
    .sig_o (shift_sig_s),
    .grs_o (shift_grs_s)
  );

  // Stage 2 register: hold the aligned result until downstream takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      big_q       <= '0;
      small_q     <= '0;
      exp_q       <= '0;
      grs_q       <= GRS_ZERO;
      swap_q      <= 1'b0;
    end else if (s2_en_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        big_q   <= s1_big_q;
        small_q <= shift_sig_s;
        exp_q   <= s1_exp_q;
        grs_q   <= shift_grs_s;
        swap_q  <= s1_swap_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign big_sig   = big_q;
  assign small_sig = small_q;
  assign grs       = grs_q;
  assign exp_out   = exp_q;
  assign swapped   = swap_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed self-checking bench for fp_align_pipe (default 8/23 widths).
// Expected grs values follow FP_ALIGN_STICKY_EN.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] big_sig, small_sig;
  logic [2:0]  grs;
  logic [7:0]  exp_out;
  logic        swapped;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  fp_align_pipe dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_exp    (a_exp),
    .b_exp    (b_exp),
    .a_frac   (a_frac),
    .b_frac   (b_frac),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .big_sig  (big_sig),
    .small_sig(small_sig),
    .grs      (grs),
    .exp_out  (exp_out),
    .swapped  (swapped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one pair with an empty pipeline and wait (bounded) for its result.
  task automatic apply_and_wait(input logic [7:0] ae, input logic [22:0] af,
                                input logic [7:0] be, input logic [22:0] bf,
                                output int lat);
    a_exp = ae; a_frac = af; b_exp = be; b_frac = bf;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_exp = 8'h00; b_exp = 8'h00; a_frac = 23'h0; b_frac = 23'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if ({big_sig, small_sig, grs, exp_out, swapped} !== 60'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h/%h/%b/%h/%b expected all zero",
                        big_sig, small_sig, grs, exp_out, swapped);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    int lat;
    apply_and_wait(8'h82, 23'h0, 8'h80, 23'h0, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected 2", lat);
    end
    n_cmp++;
    if (big_sig !== 24'h800000 || small_sig !== 24'h200000) begin
      n_bad++; $display("FAIL basic_sigs: got %h/%h expected 800000/200000", big_sig, small_sig);
    end
    n_cmp++;
    if (grs !== 3'b000 || exp_out !== 8'h82 || swapped !== 1'b0) begin
      n_bad++; $display("FAIL basic_meta: got grs=%b exp=%h sw=%b expected 000/82/0", grs, exp_out, swapped);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_single: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_swap;
    int lat;
    apply_and_wait(8'h7F, 23'h0, 8'h81, 23'h400000, lat);
    n_cmp++;
    if (lat !== 2 || big_sig !== 24'hC00000 || small_sig !== 24'h200000) begin
      n_bad++; $display("FAIL swap_sigs: lat=%0d got %h/%h expected 2 C00000/200000", lat, big_sig, small_sig);
    end
    n_cmp++;
    if (exp_out !== 8'h81 || swapped !== 1'b1 || grs !== 3'b000) begin
      n_bad++; $display("FAIL swap_meta: got exp=%h sw=%b grs=%b expected 81/1/000", exp_out, swapped, grs);
    end
  endtask

  task automatic test_sticky;
    int lat;
    logic [2:0] exp_grs;
    exp_grs = STICKY ? 3'b111 : 3'b000;
    apply_and_wait(8'h80, 23'h0, 8'h7D, 23'h000007, lat);
    n_cmp++;
    if (big_sig !== 24'h800000 || small_sig !== 24'h100000) begin
      n_bad++; $display("FAIL sticky_sigs: got %h/%h expected 800000/100000", big_sig, small_sig);
    end
    n_cmp++;
    if (grs !== exp_grs || exp_out !== 8'h80 || swapped !== 1'b0) begin
      n_bad++; $display("FAIL sticky_grs: got grs=%b exp=%h sw=%b expected %b/80/0", grs, exp_out, swapped, exp_grs);
    end
  endtask

  task automatic test_saturate_subnormal;
    int lat;
    logic [2:0] exp_grs;
    exp_grs = STICKY ? 3'b001 : 3'b000;
    apply_and_wait(8'hC0, 23'h0, 8'h80, 23'h0, lat);
    n_cmp++;
    if (small_sig !== 24'h0 || grs !== exp_grs || big_sig !== 24'h800000 || exp_out !== 8'hC0) begin
      n_bad++; $display("FAIL saturate: got small=%h grs=%b big=%h exp=%h expected 0/%b/800000/C0",
                        small_sig, grs, big_sig, exp_out, exp_grs);
    end
    // Subnormal B against exponent 2: difference 1 only if B counts as exponent 1.
    exp_grs = STICKY ? 3'b100 : 3'b000;
    apply_and_wait(8'h02, 23'h0, 8'h00, 23'h000001, lat);
    n_cmp++;
    if (small_sig !== 24'h0 || grs !== exp_grs || exp_out !== 8'h02 || swapped !== 1'b0) begin
      n_bad++; $display("FAIL subnormal_shift: got small=%h grs=%b exp=%h sw=%b expected 0/%b/02/0",
                        small_sig, grs, exp_out, swapped, exp_grs);
    end
    // Both subnormal: equal exponents, larger fraction wins, effective exponent 1.
    apply_and_wait(8'h00, 23'h0, 8'h00, 23'h000001, lat);
    n_cmp++;
    if (big_sig !== 24'h000001 || small_sig !== 24'h0 || exp_out !== 8'h01 || swapped !== 1'b1 || grs !== 3'b000) begin
      n_bad++; $display("FAIL subnormal_pair: got big=%h small=%h exp=%h sw=%b grs=%b expected 000001/0/01/1/000",
                        big_sig, small_sig, exp_out, swapped, grs);
    end
    // Exact tie keeps A as larger.
    apply_and_wait(8'h90, 23'h123456, 8'h90, 23'h123456, lat);
    n_cmp++;
    if (swapped !== 1'b0 || big_sig !== 24'h923456 || small_sig !== 24'h923456 || exp_out !== 8'h90) begin
      n_bad++; $display("FAIL tie: got sw=%b big=%h small=%h exp=%h expected 0/923456/923456/90",
                        swapped, big_sig, small_sig, exp_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ae[3], be[3], exp_e[3], got_exp[3], hold_exp;
    logic [22:0] af[3], bf[3];
    logic [23:0] big_e[3], got_big[3], hold_big;
    int sent, got, cyc;
    logic acc_i, held_ok;
    ae = '{8'h82, 8'h7F, 8'h80};  af = '{23'h0, 23'h0, 23'h0};
    be = '{8'h80, 8'h81, 8'h7D};  bf = '{23'h0, 23'h400000, 23'h000007};
    exp_e = '{8'h82, 8'h81, 8'h80};
    big_e = '{24'h800000, 24'hC00000, 24'h800000};
    out_ready = 1'b0; sent = 0;
    for (int c = 0; c < 4; c++) begin
      if (sent < 3) begin
        a_exp = ae[sent]; a_frac = af[sent]; b_exp = be[sent]; b_frac = bf[sent];
        in_valid = 1'b1;
      end
      acc_i = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_i) sent++;
    end
    n_cmp++;
    if (sent !== 2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_fill: accepted=%0d in_ready=%b expected 2/0", sent, in_ready);
    end
    hold_big = big_sig; hold_exp = exp_out; held_ok = out_valid;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!out_valid || big_sig !== hold_big || exp_out !== hold_exp || in_ready) held_ok = 1'b0;
    end
    n_cmp++;
    if (held_ok !== 1'b1 || hold_exp !== 8'h82) begin
      n_bad++; $display("FAIL b2b_stall: stable=%b exp=%h expected 1/82", held_ok, hold_exp);
    end
    out_ready = 1'b1; got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (sent < 3) begin
        a_exp = ae[sent]; a_frac = af[sent]; b_exp = be[sent]; b_frac = bf[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc_i = in_valid && in_ready;
      if (out_valid && got < 3) begin
        got_exp[got] = exp_out; got_big[got] = big_sig; got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_i) sent++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 3) begin
      n_bad++; $display("FAIL b2b_count: got %0d results expected 3", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (got_exp[i] !== exp_e[i] || got_big[i] !== big_e[i]) begin
        n_bad++; $display("FAIL b2b_order[%0d]: got %h/%h expected %h/%h", i, got_exp[i], got_big[i], exp_e[i], big_e[i]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_no_dup: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat, stale;
    out_ready = 1'b0;
    a_exp = 8'h82; a_frac = 23'h0; b_exp = 8'h80; b_frac = 23'h0;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || big_sig !== 24'h0 || exp_out !== 8'h0) begin
      n_bad++; $display("FAIL midreset_clear: out_valid=%b big=%h exp=%h expected 0/0/0", out_valid, big_sig, exp_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_ready: in_ready=%b expected 1", in_ready);
    end
    out_ready = 1'b1; stale = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_bad++; $display("FAIL midreset_stale: saw %0d valid cycles expected 0", stale);
    end
    apply_and_wait(8'h7F, 23'h0, 8'h81, 23'h400000, lat);
    n_cmp++;
    if (lat !== 2 || exp_out !== 8'h81 || big_sig !== 24'hC00000 || swapped !== 1'b1) begin
      n_bad++; $display("FAIL midreset_first: lat=%0d exp=%h big=%h sw=%b expected 2/81/C00000/1",
                        lat, exp_out, big_sig, swapped);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_sticky();
    test_saturate_subnormal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
FP_ALIGN_PIPE -- requirements
Module: fp_align_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (excluding hidden bit).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand pair.
REQ-007 SHALL have ports a_exp, b_exp  input  EXP_W  biased exponents of operands A and B.
REQ-008 SHALL have ports a_frac, b_frac  input  MAN_W  stored fractions of A and B.
REQ-009 SHALL have port out_valid  output  1  aligned result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port big_sig  output  MAN_W+1  significand of larger-magnitude operand, unshifted.
REQ-012 SHALL have port small_sig  output  MAN_W+1  significand of smaller operand, right-shifted by exponent difference.
REQ-013 SHALL have port grs  output  3  guard, round, sticky bits of shifted-out part ({G,R,S}).
REQ-014 SHALL have port exp_out  output  EXP_W  effective exponent of larger operand.
REQ-015 SHALL have port swapped  output  1  high when B was selected as larger.

Function
REQ-016 SHALL form significand as {hidden, frac}: hidden=1 if exp!=0, else hidden=0 and effective exponent=1 (subnormal).
REQ-017 SHALL select B as larger when eff_exp_b>eff_exp_a, or exponents equal and b_frac>a_frac; otherwise A (tie -> A, swapped=0).
REQ-018 SHALL be a 2-stage pipeline: stage 1 compares/selects and registers exponent difference; stage 2 shifts and registers outputs; latency 2 cycles with out_ready high.
REQ-019 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-020 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (stage 1 advances when stage 2 empty or draining); full throughput 1/cycle.
REQ-021 SHALL hold all outputs stable while out_valid&&!out_ready.
REQ-022 SHALL preserve order; no operand pair dropped or duplicated under any stall pattern.
REQ-023 SHALL saturate shift: difference >= MAN_W+4 yields small_sig=0, grs={0,0,OR of significand}.
REQ-024 SHALL compute difference as unsigned eff_exp_big-eff_exp_small, width EXP_W, never negative.

Reset
REQ-025 SHALL on rstn low clear both stage valid flags, out_valid=0, big_sig, small_sig, grs, exp_out, swapped=0, asynchronously.
REQ-026 SHALL discard in-flight operands on reset mid-operation; first out_valid after release results only from post-reset input.
REQ-027 SHALL drive in_ready=1 from first cycle after reset release.

Configuration
REQ-028 SHALL, with FP_ALIGN_STICKY_EN defined, compute grs from shifted-out bits (G=first, R=second, S=OR of remainder).
REQ-029 SHALL, without FP_ALIGN_STICKY_EN, tie grs to 3'b000 and truncate shifted-out bits; all other behaviour identical.

Structure
REQ-030 SHALL place EXP_W/MAN_W defaults, fp_sig_t-style significand typedefs and GRS struct in shared package fp_pkg.
REQ-031 SHALL implement shift plus guard/round/sticky extraction in sub-module fp_shift_sticky, instantiated in stage 2.

Verification
REQ-032 SHALL check: a_exp=0x82,a_frac=0,b_exp=0x80,b_frac=0 -> big_sig=0x800000, small_sig=0x200000, grs=000, exp_out=0x82, swapped=0, out_valid 2 cycles after accept.
REQ-033 SHALL check: a_exp=0x7F,a_frac=0,b_exp=0x81,b_frac=0x400000 -> big_sig=0xC00000, small_sig=0x200000, exp_out=0x81, swapped=1.
REQ-034 SHALL check (macro on): a_exp=0x80,a_frac=0,b_exp=0x7D,b_frac=0x000007 -> small_sig=0x100000, grs=111; macro off -> grs=000.
REQ-035 SHALL check: a_exp=0xC0,b_exp=0x80 (diff 0x40) -> small_sig=0, grs=001 (macro on); b_exp=0,b_frac=0x000001 treated as exp 1, hidden 0.
REQ-036 SHALL check: 3 back-to-back inputs, out_ready low 5 cycles -> in_ready low after 2 accepted, outputs stable, 3 results in order once out_ready high.
REQ-037 SHALL check: rstn pulsed low with both stages full -> out_valid=0 immediately, no stale result after release.
